// File: rtl/store_trace_fifo_pkg.sv
// Shared types for the store trace buffer: one captured store entry and the drop counter width.
package store_trace_fifo_pkg;

  localparam int DROP_CNT_W = 8;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
  } store_entry_t;

endpackage

// File: rtl/store_trace_ram.sv
// DEPTH x 64-bit entry storage with wrapping read/write pointers; one write port, async read of the head.
// Writes and pointer moves land on the rising edge; the caller gates wr_en/rd_en against full/empty.
module store_trace_ram
  import store_trace_fifo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         wr_en,
  input  logic         rd_en,
  input  store_entry_t wr_entry,
  output store_entry_t rd_entry
);

  localparam int AW = $clog2(DEPTH);

  store_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end

  assign rd_entry = mem[rd_ptr];

endmodule

// File: rtl/store_trace_fifo.sv
// Passive tap on processor stores: buffers {Adr, WriteData}, head visible one cycle after push.
// Consumer pops with out_ready; stores into a full buffer without a same-cycle pop are dropped and counted.
module store_trace_fifo
  import store_trace_fifo_pkg::*;
#(
  parameter int          DEPTH      = 8,
  parameter logic [31:0] MATCH_ADR  = 32'd100,
  parameter logic [31:0] MATCH_DATA = 32'd7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    MemWrite,
  input  logic [31:0]             Adr,
  input  logic [31:0]             WriteData,
  input  logic                    clear,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_adr,
  output logic [31:0]             out_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [DROP_CNT_W-1:0]   drop_cnt,
  output logic                    done
);

  localparam int                  CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]       FULL     = CW'(DEPTH);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

  logic         full;
  logic         pop;
  logic         push;
  logic         drop;
  logic         match;
  store_entry_t wr_entry;
  store_entry_t rd_entry;

  assign full      = (count == FULL);
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready & ~clear;
  // a pop in the same cycle frees the slot, so a full buffer still accepts
  assign push      = MemWrite & (~full | pop) & ~clear;
  assign drop      = MemWrite & full & ~pop & ~clear;
  assign match     = MemWrite & (Adr == MATCH_ADR) & (WriteData == MATCH_DATA);
  assign wr_entry  = '{adr: Adr, data: WriteData};

  store_trace_ram #(.DEPTH(DEPTH)) u_ram (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .wr_en    (push),
    .rd_en    (pop),
    .wr_entry (wr_entry),
    .rd_entry (rd_entry)
  );

  assign out_adr  = rd_entry.adr;
  assign out_data = rd_entry.data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      done     <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      done     <= 1'b0;
    end else begin
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (drop) overflow <= 1'b1;
      if (drop && drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      // the completion marker counts even when its store is dropped
      if (match) done <= 1'b1;
    end
  end

endmodule

// File: doc/store_trace_fifo.md
STORE_TRACE_FIFO -- requirements
Module: store_trace_fifo

Interface
REQ-001 Parameter DEPTH, default 8, number of buffered store entries (power of two, >=2).
REQ-002 Parameter MATCH_ADR, default 32'd100, address of the completion store.
REQ-003 Parameter MATCH_DATA, default 32'd7, data value of the completion store.
REQ-004 Port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 Port MemWrite  input  1  store strobe from the processor/memory pair.
REQ-007 Port Adr  input  32  store address, sampled when MemWrite=1.
REQ-008 Port WriteData  input  32  store data, sampled when MemWrite=1.
REQ-009 Port clear  input  1  synchronous flush of entries, flags and counters.
REQ-010 Port out_valid  output  1  head entry available.
REQ-011 Port out_ready  input  1  consumer accepts head entry.
REQ-012 Port out_adr  output  32  head entry address.
REQ-013 Port out_data  output  32  head entry data.
REQ-014 Port count  output  $clog2(DEPTH)+1  entries currently held.
REQ-015 Port overflow  output  1  sticky: at least one store dropped.
REQ-016 Port drop_cnt  output  8  dropped stores, saturating at 255.
REQ-017 Port done  output  1  sticky: MATCH_DATA written to MATCH_ADR.

Function
REQ-018 A store (MemWrite=1) SHALL be pushed as {Adr, WriteData} at the rising edge of the same cycle.
REQ-019 A pop SHALL occur when out_valid=1 and out_ready=1 at a rising edge; head advances by one.
REQ-020 out_valid SHALL equal (count!=0); out_adr/out_data SHALL show the oldest entry, stable while out_valid=1 and out_ready=0.
REQ-021 No bypass: a store into an empty buffer SHALL raise out_valid one cycle after the push edge.
REQ-022 Push and pop in the same cycle with count==DEPTH SHALL accept the push (count stays DEPTH, no drop).
REQ-023 Push with count==DEPTH and no pop SHALL drop the store, set overflow, increment drop_cnt (hold at 255).
REQ-024 Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow.
REQ-026 done SHALL set at the edge where MemWrite=1, Adr==MATCH_ADR, WriteData==MATCH_DATA, even if that store is dropped.
REQ-027 clear=1 SHALL, at the next edge, zero count, pointers, overflow, drop_cnt and done, and ignore any concurrent push/pop.
REQ-028 count, overflow, drop_cnt, done SHALL be registered outputs; out_adr/out_data SHALL be a read of storage at the read pointer.

Reset
REQ-029 reset=0 SHALL immediately force count=0, pointers=0, out_valid=0, overflow=0, drop_cnt=0, done=0.
REQ-030 out_adr/out_data SHALL be don't-care while out_valid=0; storage array is not reset.
REQ-031 Reset asserted mid-stream SHALL discard all entries; first push after release SHALL land in slot 0.

Structure
REQ-032 Shared package SHALL hold the store-entry struct typedef (adr[31:0], data[31:0]) and the drop-counter width constant.
REQ-033 Storage plus pointers SHALL be one sub-module, store_trace_ram (DEPTH x 64-bit, one write and one async read port); flags/counters stay in the top of the block.
REQ-034 The block SHALL attach passively to the processor-to-memory store signals with no feedback into that path.

Verification
REQ-035 Single store Adr=100, WriteData=7, out_ready=0 -> count=1, out_valid=1 next cycle, out_adr=100, out_data=7, done=1.
REQ-036 Nine consecutive stores (DEPTH=8), out_ready=0 -> count=8, overflow=1, drop_cnt=1, head=first store.
REQ-037 Full buffer, store with out_ready=1 same cycle -> count stays 8, drop_cnt unchanged, new entry read out 8th after.
REQ-038 Stores of 0x10..0x1F with out_ready toggling each cycle -> output order matches input order across pointer wrap.
REQ-039 reset=0 pulse mid-burst with count=5 -> count=0, out_valid=0, done=0 immediately, before the next edge.
REQ-040 300 stores into a full buffer, out_ready=0 -> drop_cnt=255; then clear=1 -> all flags and count 0 next cycle.
